// File: rtl/mandel_engine.sv
// mandel_engine: scans an H_RES x V_RES frame, iterating z = z^2 + c once per cycle per pixel,
// and hands each pixel's iteration count, inside flag and address out over valid/ready.
module mandel_engine #(
   parameter int unsigned WIDTH     = 48,
   parameter int unsigned FRAC      = 40,
   parameter int unsigned ITER_BITS = 7,
   parameter int unsigned MAX_ITER  = 127,
   parameter int unsigned H_RES     = 160,
   parameter int unsigned V_RES     = 120,
   parameter int unsigned ADDR_W    = 19
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic signed [WIDTH-1:0] origin_re,
   input  logic signed [WIDTH-1:0] origin_im,
   input  logic signed [WIDTH-1:0] step,
   output logic                    pix_valid,
   input  logic                    pix_ready,
   output logic [ITER_BITS-1:0]    pix_iter,
   output logic                    pix_inside,
   output logic [ADDR_W-1:0]       pix_addr,
   output logic                    busy,
   output logic                    frame_done
);

   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned MW = PW + 1;
   localparam int unsigned XW = (H_RES > 1) ? $clog2(H_RES) : 1;
   localparam int unsigned YW = (V_RES > 1) ? $clog2(V_RES) : 1;
   // |z|^2 > 4.0 in the 2*FRAC fraction of the full-precision products
   localparam logic [PW:0]          EscLimit = MW'(1) << (2 * FRAC + 2);
   localparam logic [ITER_BITS-1:0] MaxIterN = ITER_BITS'(MAX_ITER);
   localparam logic [XW-1:0]        LastX    = XW'(H_RES - 1);
   localparam logic [YW-1:0]        LastY    = YW'(V_RES - 1);

   typedef enum logic [1:0] {StIdle, StIterate, StOutput} state_e;

   state_e                  state_q, state_d;
   logic signed [WIDTH-1:0] zr_q, zi_q, c_re_q, c_im_q, org_re_q, step_q;
   logic [ITER_BITS-1:0]    n_q;
   logic [XW-1:0]           x_q;
   logic [YW-1:0]           y_q;
   logic [ADDR_W-1:0]       addr_q;

   logic signed [PW-1:0]    sr, si, pr, diff, dbl;
   logic [PW:0]             mag;
   logic signed [WIDTH-1:0] zr_next, zi_next;
   logic                    escape, at_max, last_x, last_y, accept;

   // Full-precision squares, escape magnitude and the next z (wrapping to WIDTH)
   always_comb begin
      sr      = PW'(zr_q) * PW'(zr_q);
      si      = PW'(zi_q) * PW'(zi_q);
      pr      = PW'(zr_q) * PW'(zi_q);
      mag     = {1'b0, sr} + {1'b0, si};
      diff    = sr - si;
      dbl     = pr <<< 1;
      zr_next = WIDTH'(diff >>> FRAC) + c_re_q;
      zi_next = WIDTH'(dbl >>> FRAC) + c_im_q;
   end

   assign escape    = mag > EscLimit;
   assign at_max    = (n_q == MaxIterN);
   assign last_x    = (x_q == LastX);
   assign last_y    = (y_q == LastY);
   // frame_done is high on the first IDLE cycle; start is not taken then
   assign accept    = start && !frame_done;
   assign pix_valid = (state_q == StOutput);
   assign busy      = (state_q != StIdle);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // Next-state decode
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (accept) state_d = StIterate;
         StIterate: if (escape || at_max) state_d = StOutput;
         StOutput:  if (pix_ready) state_d = (last_x && last_y) ? StIdle : StIterate;
         default:   state_d = StIdle;
      endcase
   end

   // Datapath: c/z/n, scan position and registered pixel result
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         zr_q       <= '0;
         zi_q       <= '0;
         c_re_q     <= '0;
         c_im_q     <= '0;
         org_re_q   <= '0;
         step_q     <= '0;
         n_q        <= '0;
         x_q        <= '0;
         y_q        <= '0;
         addr_q     <= '0;
         pix_iter   <= '0;
         pix_inside <= 1'b0;
         pix_addr   <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  org_re_q <= origin_re;
                  step_q   <= step;
                  c_re_q   <= origin_re;
                  c_im_q   <= origin_im;
                  zr_q     <= '0;
                  zi_q     <= '0;
                  n_q      <= '0;
                  x_q      <= '0;
                  y_q      <= '0;
                  addr_q   <= '0;
               end
            end
            StIterate: begin
               if (escape) begin
                  pix_iter   <= n_q;
                  pix_inside <= 1'b0;
                  pix_addr   <= addr_q;
               end else if (at_max) begin
                  pix_iter   <= MaxIterN;
                  pix_inside <= 1'b1;
                  pix_addr   <= addr_q;
               end else begin
                  zr_q <= zr_next;
                  zi_q <= zi_next;
                  n_q  <= n_q + ITER_BITS'(1);
               end
            end
            StOutput: begin
               if (pix_ready) begin
                  if (last_x && last_y) begin
                     frame_done <= 1'b1;
                  end else begin
                     zr_q   <= '0;
                     zi_q   <= '0;
                     n_q    <= '0;
                     addr_q <= addr_q + ADDR_W'(1);
                     if (last_x) begin
                        x_q    <= '0;
                        y_q    <= y_q + YW'(1);
                        c_re_q <= org_re_q;
                        c_im_q <= c_im_q - step_q;
                     end else begin
                        x_q    <= x_q + XW'(1);
                        c_re_q <= c_re_q + step_q;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
